// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline boundary registers:
// state encoding, occupancy width, per-boundary field widths and bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int OCC_W = 2;

    // Per-boundary field widths and bubble control values
    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int ID_EX_DATA_W  = 96;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;

    localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_BUBBLE  = 8'h00;
    localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_BUBBLE  = 8'h00;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = 8'h00;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = 8'h00;

    // Number of held entries for a given state
    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        logic [OCC_W-1:0] occ;
        case (s)
            PS_EMPTY: occ = 2'd0;
            PS_BUSY:  occ = 2'd1;
            PS_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter used to count downstream stall cycles.
module pipe_stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, sticking at the all-ones value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Generic pipeline boundary register with valid/ready handshake and a
// two-entry skid buffer (main + skid). in_ready is registered so there is
// no combinational path from out_ready to in_ready. The main register is
// reloaded with the bubble/zero value whenever it becomes empty, so the
// outputs are masked without any output-side logic.
// Optional feature macro: ELASTIC_PIPE_STALL_CNT_EN adds stall_cycles.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef ELASTIC_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    pipe_state_e       state_r, nxt_state_s;
    logic [CTRL_W-1:0] main_ctrl_r, nxt_main_ctrl_s;
    logic [DATA_W-1:0] main_data_r, nxt_main_data_s;
    logic [CTRL_W-1:0] skid_ctrl_r, nxt_skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_r, nxt_skid_data_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [OCC_W-1:0]  occupancy_r;
    logic              in_fire_s;
    logic              out_fire_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and storage update selection; flush overrides the handshake
    always_comb begin
        nxt_state_s     = state_r;
        nxt_main_ctrl_s = main_ctrl_r;
        nxt_main_data_s = main_data_r;
        nxt_skid_ctrl_s = skid_ctrl_r;
        nxt_skid_data_s = skid_data_r;
        if (flush) begin
            nxt_state_s     = PS_EMPTY;
            nxt_main_ctrl_s = CTRL_BUBBLE;
            nxt_main_data_s = {DATA_W{1'b0}};
            nxt_skid_ctrl_s = {CTRL_W{1'b0}};
            nxt_skid_data_s = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                PS_EMPTY: begin
                    if (in_fire_s) begin
                        nxt_state_s     = PS_BUSY;
                        nxt_main_ctrl_s = in_ctrl;
                        nxt_main_data_s = in_data;
                    end else begin
                        nxt_state_s = PS_EMPTY;
                    end
                end
                PS_BUSY: begin
                    if (in_fire_s && !out_fire_s) begin
                        nxt_state_s     = PS_FULL;
                        nxt_skid_ctrl_s = in_ctrl;
                        nxt_skid_data_s = in_data;
                    end else if (in_fire_s && out_fire_s) begin
                        nxt_state_s     = PS_BUSY;
                        nxt_main_ctrl_s = in_ctrl;
                        nxt_main_data_s = in_data;
                    end else if (out_fire_s) begin
                        nxt_state_s     = PS_EMPTY;
                        nxt_main_ctrl_s = CTRL_BUBBLE;
                        nxt_main_data_s = {DATA_W{1'b0}};
                    end else begin
                        nxt_state_s = PS_BUSY;
                    end
                end
                PS_FULL: begin
                    if (out_fire_s) begin
                        nxt_state_s     = PS_BUSY;
                        nxt_main_ctrl_s = skid_ctrl_r;
                        nxt_main_data_s = skid_data_r;
                        nxt_skid_ctrl_s = {CTRL_W{1'b0}};
                        nxt_skid_data_s = {DATA_W{1'b0}};
                    end else begin
                        nxt_state_s = PS_FULL;
                    end
                end
                default: begin
                    nxt_state_s     = PS_EMPTY;
                    nxt_main_ctrl_s = CTRL_BUBBLE;
                    nxt_main_data_s = {DATA_W{1'b0}};
                    nxt_skid_ctrl_s = {CTRL_W{1'b0}};
                    nxt_skid_data_s = {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // State, storage and registered handshake/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= PS_EMPTY;
            main_ctrl_r <= CTRL_BUBBLE;
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            occupancy_r <= {OCC_W{1'b0}};
        end else begin
            state_r     <= nxt_state_s;
            main_ctrl_r <= nxt_main_ctrl_s;
            main_data_r <= nxt_main_data_s;
            skid_ctrl_r <= nxt_skid_ctrl_s;
            skid_data_r <= nxt_skid_data_s;
            in_ready_r  <= (nxt_state_s != PS_FULL);
            out_valid_r <= (nxt_state_s != PS_EMPTY);
            occupancy_r <= occ_of(nxt_state_s);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

`ifdef ELASTIC_PIPE_STALL_CNT_EN
    pipe_stall_counter #(
        .CNT_W (32)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid_r & ~out_ready),
        .count (stall_cycles)
    );
`else
    // Stall counting disabled: no counter or port
`endif

endmodule
